// File: rtl/mem_access_pkg.sv
// rtl/mem_access_pkg.sv - shared types, lane masks and size helpers for mem_access_unit
package mem_access_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10
  } size_t;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    WRITE  = 2'b10,
    RESP   = 2'b11
  } state_t;

  localparam logic [31:0] LANE_BYTE_MASK = 32'h0000_00FF;
  localparam logic [31:0] LANE_HALF_MASK = 32'h0000_FFFF;

  // The reserved encoding 2'b11 behaves as a full word.
  function automatic size_t norm_size(input logic [1:0] s);
    return (s == 2'b11) ? SIZE_WORD : size_t'(s);
  endfunction

  // Byte offset inside the word once bits below the access size are dropped.
  function automatic logic [1:0] lane_offset(input size_t s, input logic [1:0] a);
    case (s)
      SIZE_BYTE: return a;
      SIZE_HALF: return {a[1], 1'b0};
      default:   return 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_load_align.sv
// rtl/mem_access_unit_load_align.sv - selects the addressed lane of a word and sign/zero extends it
module load_align
  import mem_access_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  off,
  input  size_t       size,
  input  logic        is_unsigned,
  output logic [31:0] result
);

  logic [31:0] shifted;

  always_comb begin
    shifted = word >> {off, 3'b000};
    case (size)
      SIZE_BYTE: result = {{24{shifted[7] & ~is_unsigned}}, shifted[7:0]};
      SIZE_HALF: result = {{16{shifted[15] & ~is_unsigned}}, shifted[15:0]};
      default:   result = shifted;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - load/store initiator with read-modify-write sub-word stores; optional MEM_ACCESS_MISALIGN_CHECK_EN
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic                  i_req_we,
  input  logic [1:0]            i_req_size,
  input  logic                  i_req_unsigned,
  input  logic [ADDR_WIDTH-1:0] i_req_addr,
  input  logic [DATA_WIDTH-1:0] i_req_wdata,
  output logic                  o_resp_valid,
  output logic [DATA_WIDTH-1:0] o_resp_rdata,
  output logic                  o_resp_misaligned,
  output logic                  o_mem_we,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [DATA_WIDTH-1:0] o_mem_wdata,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata
);

  if (DATA_WIDTH != 32) begin : g_width_check
    $error("mem_access_unit supports DATA_WIDTH = 32 only");
  end

  state_t                  state_q, state_d;
  logic                    we_q, uns_q;
  size_t                   size_q, req_size;
  logic [1:0]              off_q;
  logic [ADDR_WIDTH-1:2]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q, result_q, merge_q;
  logic [DATA_WIDTH-1:0]   load_word, lane_mask, merged;
  logic                    accept, req_mis;

  assign accept   = i_req_valid && o_req_ready;
  assign req_size = norm_size(i_req_size);

`ifdef MEM_ACCESS_MISALIGN_CHECK_EN
  logic mis_q;
  assign req_mis = ((req_size == SIZE_HALF) && i_req_addr[0]) ||
                   ((req_size == SIZE_WORD) && (i_req_addr[1:0] != 2'b00));
  assign o_resp_misaligned = (state_q == RESP) && mis_q && !rst;

  always_ff @(posedge clk) begin
    if (rst)         mis_q <= 1'b0;
    else if (accept) mis_q <= req_mis;
  end
`else
  assign req_mis           = 1'b0;
  assign o_resp_misaligned = 1'b0;
`endif

  load_align u_load_align (
    .word        (i_mem_rdata),
    .off         (off_q),
    .size        (size_q),
    .is_unsigned (uns_q),
    .result      (load_word)
  );

  // Sub-word merge: keep the captured word, overwrite only the addressed lane.
  always_comb begin
    lane_mask = ((size_q == SIZE_BYTE) ? LANE_BYTE_MASK : LANE_HALF_MASK) << {off_q, 3'b000};
    merged    = (merge_q & ~lane_mask) | ((wdata_q << {off_q, 3'b000}) & lane_mask);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      we_q     <= 1'b0;
      uns_q    <= 1'b0;
      size_q   <= SIZE_BYTE;
      off_q    <= 2'b00;
      addr_q   <= '0;
      wdata_q  <= '0;
      result_q <= '0;
      merge_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        we_q     <= i_req_we;
        uns_q    <= i_req_unsigned;
        size_q   <= req_size;
        off_q    <= lane_offset(req_size, i_req_addr[1:0]);
        addr_q   <= i_req_addr[ADDR_WIDTH-1:2];
        wdata_q  <= i_req_wdata;
        result_q <= '0;
      end
      if (state_q == ACCESS) begin
        if (we_q) merge_q  <= i_mem_rdata;
        else      result_q <= load_word;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = req_mis ? RESP : ACCESS;
      ACCESS:  state_d = (we_q && (size_q != SIZE_WORD)) ? WRITE : RESP;
      WRITE:   state_d = RESP;
      default: state_d = IDLE;
    endcase
  end

  assign o_req_ready  = (state_q == IDLE) && !rst;
  assign o_resp_valid = (state_q == RESP) && !rst;
  assign o_resp_rdata = result_q;
  assign o_mem_we     = !rst && (((state_q == ACCESS) && we_q && (size_q == SIZE_WORD)) ||
                                 (state_q == WRITE));
  assign o_mem_addr   = {addr_q, 2'b00};
  assign o_mem_wdata  = (size_q == SIZE_WORD) ? wdata_q : merged;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - self-checking bench for mem_access_unit with a transaction-level model
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_req_valid = 1'b0;
  logic        o_req_ready;
  logic        i_req_we = 1'b0;
  logic [1:0]  i_req_size = 2'b00;
  logic        i_req_unsigned = 1'b0;
  logic [63:0] i_req_addr = '0;
  logic [31:0] i_req_wdata = '0;
  logic        o_resp_valid;
  logic [31:0] o_resp_rdata;
  logic        o_resp_misaligned;
  logic        o_mem_we;
  logic [63:0] o_mem_addr;
  logic [31:0] o_mem_wdata;
  logic [31:0] i_mem_rdata;

  logic [31:0] mem [0:255];
  logic [31:0] ref_mem [0:255];
  int cyc = 0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_access_unit #(.ADDR_WIDTH(64), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_req_we(i_req_we), .i_req_size(i_req_size), .i_req_unsigned(i_req_unsigned),
    .i_req_addr(i_req_addr), .i_req_wdata(i_req_wdata),
    .o_resp_valid(o_resp_valid), .o_resp_rdata(o_resp_rdata),
    .o_resp_misaligned(o_resp_misaligned),
    .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
    .i_mem_rdata(i_mem_rdata)
  );

  assign i_mem_rdata = mem[o_mem_addr[9:2]];

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[8'h40] = 32'h8765_43A1;
  end

  always @(posedge clk) if (o_mem_we) mem[o_mem_addr[9:2]] <= o_mem_wdata;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Transaction model: one outstanding request, expectations derived at accept time.
  initial begin
    bit          pend, has_wr, exp_ready, exp_resp, exp_we, mis;
    int          resp_cyc, wr_cyc, off;
    logic [31:0] exp_rdata, exp_wdata, w, v;
    logic [63:0] exp_waddr;
    logic [1:0]  sz;
    bit          exp_mis;
    pend = 0; has_wr = 0; resp_cyc = 0; wr_cyc = 0; exp_mis = 0;
    exp_rdata = 0; exp_wdata = 0; exp_waddr = 0;
    for (int i = 0; i < 256; i++) ref_mem[i] = 32'h0;
    ref_mem[8'h40] = 32'h8765_43A1;
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("rst_ready", o_req_ready, 0);
        chk("rst_resp_valid", o_resp_valid, 0);
        chk("rst_mem_we", o_mem_we, 0);
        chk("rst_misaligned", o_resp_misaligned, 0);
        pend = 0;
      end else begin
        exp_ready = !pend;
        chk("ready", o_req_ready, exp_ready);
        exp_resp = pend && (cyc == resp_cyc);
        chk("resp_valid", o_resp_valid, exp_resp);
        if (exp_resp) begin
          chk("resp_rdata", o_resp_rdata, exp_rdata);
          chk("resp_misaligned", o_resp_misaligned, exp_mis);
        end
        exp_we = pend && has_wr && (cyc == wr_cyc);
        chk("mem_we", o_mem_we, exp_we);
        if (exp_we) begin
          chk("mem_addr", o_mem_addr, exp_waddr);
          chk("mem_wdata", o_mem_wdata, exp_wdata);
          ref_mem[exp_waddr[9:2]] = exp_wdata;
        end
        if (exp_resp) pend = 0;
        if (i_req_valid && exp_ready) begin
          sz = (i_req_size == 2'd3) ? 2'd2 : i_req_size;
          w  = ref_mem[i_req_addr[9:2]];
`ifdef MEM_ACCESS_MISALIGN_CHECK_EN
          mis = ((sz == 2'd1) && i_req_addr[0]) || ((sz == 2'd2) && (i_req_addr[1:0] != 2'd0));
`else
          mis = 0;
`endif
          off = (sz == 2'd0) ? int'(i_req_addr[1:0]) : (sz == 2'd1) ? (i_req_addr[1] ? 2 : 0) : 0;
          pend = 1; has_wr = 0; exp_mis = mis; exp_rdata = 0;
          exp_waddr = {i_req_addr[63:2], 2'b00};
          if (mis) begin
            resp_cyc = cyc + 1;
          end else if (!i_req_we) begin
            resp_cyc = cyc + 2;
            v = w >> (8 * off);
            if (sz == 2'd0) begin
              v = v % 256;
              if (!i_req_unsigned && v >= 128) v = v - 256;
            end else if (sz == 2'd1) begin
              v = v % 65536;
              if (!i_req_unsigned && v >= 32768) v = v - 65536;
            end
            exp_rdata = v;
          end else begin
            has_wr = 1;
            exp_wdata = w;
            if (sz == 2'd0)      exp_wdata[8*off +: 8]  = i_req_wdata[7:0];
            else if (sz == 2'd1) exp_wdata[8*off +: 16] = i_req_wdata[15:0];
            else                 exp_wdata = i_req_wdata;
            resp_cyc = cyc + ((sz == 2'd2) ? 2 : 3);
            wr_cyc   = resp_cyc - 1;
          end
        end
      end
    end
  end

  task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [63:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output int lat);
    int acc;
    bit got;
    @(posedge clk); #1;
    i_req_valid = 1; i_req_we = we; i_req_size = sz; i_req_unsigned = uns;
    i_req_addr = a; i_req_wdata = wd;
    acc = -1;
    for (int i = 0; i < 20 && acc < 0; i++) begin
      @(negedge clk);
      if (o_req_ready) acc = cyc;
    end
    @(posedge clk); #1;
    i_req_valid = 0;
    got = 0; rd = 0; lat = -1;
    if (acc < 0) begin
      errors++;
      $display("FAIL accept_timeout: addr %0h", a);
    end else begin
      for (int i = 0; i < 20 && !got; i++) begin
        @(negedge clk);
        if (o_resp_valid) begin
          got = 1; rd = o_resp_rdata; lat = cyc - acc;
        end
      end
      if (!got) begin
        errors++;
        $display("FAIL resp_timeout: addr %0h", a);
      end
    end
  endtask

  initial begin
    logic [31:0] rd;
    int lat, c0, c1, pulses;
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    int lat, c0, c1, pulses;
    repeat (3) @(posedge clk);
    #1 rst = 0;

    do_req(0, 2'd0, 0, 64'h100, 0, rd, lat);
    chk("lb_100", rd, 32'hFFFF_FFA1); chk("lb_latency", lat, 2);
    do_req(0, 2'd0, 1, 64'h100, 0, rd, lat);
    chk("lbu_100", rd, 32'h0000_00A1);
    do_req(0, 2'd0, 0, 64'h101, 0, rd, lat);
    chk("lb_101", rd, 32'h0000_0043);
    do_req(0, 2'd1, 0, 64'h102, 0, rd, lat);
    chk("lh_102", rd, 32'hFFFF_8765);
    do_req(0, 2'd3, 0, 64'h100, 0, rd, lat);
    chk("size11_word", rd, 32'h8765_43A1);

    do_req(1, 2'd1, 0, 64'h102, 32'h0000_BEEF, rd, lat);
    chk("sh_latency", lat, 3); chk("sh_rdata", rd, 0);
    chk("sh_mem", mem[8'h40], 32'hBEEF_43A1);
    do_req(0, 2'd0, 0, 64'h103, 0, rd, lat);
    chk("lb_103", rd, 32'hFFFF_FFBE);

    do_req(1, 2'd2, 0, 64'h104, 32'hDEAD_BEEF, rd, lat);
    chk("sw_latency", lat, 2);
    do_req(0, 2'd2, 0, 64'h104, 0, rd, lat);
    chk("lw_104", rd, 32'hDEAD_BEEF);

    do_req(0, 2'd2, 0, 64'h102, 0, rd, lat);
`ifdef MEM_ACCESS_MISALIGN_CHECK_EN
    chk("lw_102_misaligned", rd, 0); chk("lw_102_latency", lat, 1);
`else
    chk("lw_102_forced", rd, 32'hBEEF_43A1); chk("lw_102_latency", lat, 2);
`endif

    // sb interrupted by reset in its WRITE cycle
    @(posedge clk); #1;
    i_req_valid = 1; i_req_we = 1; i_req_size = 2'd0; i_req_unsigned = 0;
    i_req_addr = 64'h101; i_req_wdata = 32'h55;
    c0 = -1;
    for (int i = 0; i < 20 && c0 < 0; i++) begin
      @(negedge clk);
      if (o_req_ready) c0 = cyc;
    end
    @(posedge clk); #1 i_req_valid = 0;
    @(posedge clk); #1 rst = 1;
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    chk("ready_after_rst", o_req_ready, 1);
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (o_resp_valid) pulses++;
    end
    chk("rst_no_resp", pulses, 0);
    chk("rst_mem_unchanged", mem[8'h40], 32'hBEEF_43A1);

    // back-to-back: valid held high across lw then sw
    @(posedge clk); #1;
    i_req_valid = 1; i_req_we = 0; i_req_size = 2'd2; i_req_addr = 64'h104; i_req_wdata = 0;
    c0 = -1; c1 = -1; pulses = 0;
    for (int i = 0; i < 20 && c0 < 0; i++) begin
      @(negedge clk);
      if (o_req_ready) c0 = cyc;
    end
    @(posedge clk); #1;
    i_req_we = 1; i_req_addr = 64'h108; i_req_wdata = 32'h1122_3344;
    for (int i = 0; i < 20 && c1 < 0; i++) begin
      @(negedge clk);
      if (o_resp_valid) pulses++;
      if (o_req_ready) c1 = cyc;
    end
    @(posedge clk); #1 i_req_valid = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (o_resp_valid) pulses++;
    end
    chk("b2b_second_accept", c1 - c0, 3);
    chk("b2b_pulses", pulses, 2);
    chk("b2b_sw_mem", mem[8'h42], 32'h1122_3344);

    for (int i = 0; i < 256; i++)
      if (mem[i] !== ref_mem[i]) chk("final_mem", mem[i], ref_mem[i]);
    chk("final_mem_100", ref_mem[8'h40], mem[8'h40]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
